// File: rtl/sr_pkg.sv
// Shared constants for the serial byte link: word size, default bit order,
// count-width helper and the two-state transmit encoding.
package sr_pkg;

  localparam int SR_WORD_W    = 8;
  localparam bit SR_MSB_FIRST = 1'b1;

  localparam logic [0:0] SR_IDLE  = 1'b0;
  localparam logic [0:0] SR_SHIFT = 1'b1;

  // Bits needed to hold values 0..n-1; always at least 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/piso_cell.sv
// One shift-register stage: load/shift select feeding an enabled flop
// with asynchronous active-low clear.
module piso_cell (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sel_load,
  input  logic load_bit,
  input  logic shift_bit,
  output logic q
);

  logic d;

  assign d = sel_load ? load_bit : shift_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sr_piso_eight.sv
// Parallel-in/serial-out transmitter: accepts a word on load_valid/load_ready
// and shifts it out one bit per clock, flagging the word's final bit.
module sr_piso_eight
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WORD_W,
  parameter bit MSB_FIRST = SR_MSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH:1]   pdata,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_last
);

  localparam int CW = clog2(WIDTH + 1);

  // Handshake: a word transfers on a rising edge where load_valid and
  // load_ready are both high; the source holds load_valid until then.
  logic [CW-1:0]  cnt;
  logic [WIDTH:1] sreg;
  logic [WIDTH:1] load_vec;
  logic [WIDTH:1] shift_vec;
  logic           first_bit;
  logic           next_bit;
  logic           accept;
  logic           cell_en;
  logic [0:0]     state;

  assign state      = q_valid ? SR_SHIFT : SR_IDLE;
  assign load_ready = (cnt == '0);
  assign accept     = load_valid && load_ready;
  assign cell_en    = accept || (cnt != '0);

  // The word is pre-shifted by one on load because its first bit goes
  // straight to q on the accepting edge.
  generate
    if (MSB_FIRST) begin : g_msb
      assign load_vec  = {pdata[WIDTH-1:1], 1'b0};
      assign shift_vec = {sreg[WIDTH-1:1], 1'b0};
      assign first_bit = pdata[WIDTH];
      assign next_bit  = sreg[WIDTH];
    end else begin : g_lsb
      assign load_vec  = {1'b0, pdata[WIDTH:2]};
      assign shift_vec = {1'b0, sreg[WIDTH:2]};
      assign first_bit = pdata[1];
      assign next_bit  = sreg[1];
    end
  endgenerate

  for (genvar i = 1; i <= WIDTH; i++) begin : g_cell
    piso_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .en        (cell_en),
      .sel_load  (accept),
      .load_bit  (load_vec[i]),
      .shift_bit (shift_vec[i]),
      .q         (sreg[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      q_last  <= 1'b0;
    end else if (accept) begin
      cnt     <= CW'(WIDTH - 1);
      q       <= first_bit;
      q_valid <= 1'b1;
      q_last  <= 1'b0;
    end else if (state == SR_SHIFT) begin
      if (cnt != '0) begin
        cnt    <= cnt - CW'(1);
        q      <= next_bit;
        q_last <= (cnt == CW'(1));
      end else begin
        q       <= 1'b0;
        q_valid <= 1'b0;
        q_last  <= 1'b0;
      end
    end
  end

endmodule
